// File: rtl/shift_scheduler_pkg.sv
// Shared types for the shift scheduler: FSM states, requester count and operand types.
package shift_sched_pkg;
  localparam int NREQ = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [7:0] byte_t;
  typedef logic [2:0] amt_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on contention the requester other than 'last' wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [0:0] last,
  input  logic       en,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = last[0] ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end
endmodule

// File: rtl/shifts.sv
// Combinational 8-bit rotator: ir=0 rotates right, ir=1 rotates left, by amt bits.
module shifts (
  input  logic [7:0] A,
  input  logic       ir,
  input  logic [2:0] amt,
  output logic [7:0] Y
);
  logic [3:0] inv;

  // For amt=0, shifting by 8 yields zero, so the OR leaves A unchanged.
  assign inv = 4'd8 - {1'b0, amt};
  assign Y   = ir ? ((A << amt) | (A >> inv))
                  : ((A >> amt) | (A << inv));
endmodule

// File: rtl/shift_scheduler.sv
// Arbitrates two rotate commands and iterates the granted one through the shared rotator.
module shift_scheduler
  import shift_sched_pkg::*;
#(
  parameter int REP_W = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][7:0]        req_data,
  input  logic [NREQ-1:0]             req_dir,
  input  logic [NREQ-1:0][2:0]        req_amt,
  input  logic [NREQ-1:0][REP_W-1:0]  req_reps,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [7:0]                  rsp_data,
  output logic                        rsp_id,
  output logic                        busy
);
  state_t           state, state_nxt;
  logic             busy_q;
  logic [0:0]       last_grant;
  byte_t            acc;
  logic             dir_q;
  amt_t             amt_q;
  logic [REP_W-1:0] cnt;
  logic             id_q;

  logic [1:0]       grant;
  logic             accept;
  logic             g;
  byte_t            y;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (last_grant),
    .en    (state == IDLE),
    .grant (grant)
  );

  shifts u_shifts (
    .A   (acc),
    .ir  (dir_q),
    .amt (amt_q),
    .Y   (y)
  );

  assign accept = |(req_valid & grant);
  assign g      = grant[1];

  // Control state: the only registers cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      if (accept) last_grant <= g;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)          state_nxt = RUN;
      RUN:     if (cnt == '0)       state_nxt = DONE;
      DONE:    if (rsp_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Operand and pass counter; outputs mask these outside DONE, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc   <= req_data[g];
      dir_q <= req_dir[g];
      amt_q <= req_amt[g];
      cnt   <= req_reps[g];
      id_q  <= g;
    end else if (state == RUN) begin
      acc <= y;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    req_ready = (state == IDLE) ? grant : 2'b00;
    rsp_valid = (state == DONE);
    rsp_data  = (state == DONE) ? acc : 8'h00;
    rsp_id    = (state == DONE) ? id_q : 1'b0;
    busy      = busy_q;
  end
endmodule

// File: tb/tb_shift_scheduler.sv
// Directed bench for shift_scheduler with hand-computed expected results.
module tb_shift_scheduler;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][7:0]  req_data;
  logic [1:0]       req_dir;
  logic [1:0][2:0]  req_amt;
  logic [1:0][1:0]  req_reps;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic             rsp_id;
  logic             busy;

  int nerr = 0;
  int nchk = 0;
  int lat;

  shift_scheduler #(.REP_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_dir   (req_dir),
    .req_amt   (req_amt),
    .req_reps  (req_reps),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nchk++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int p, input logic [7:0] d, input logic dr,
                         input logic [2:0] a, input logic [1:0] r);
    req_data[p] = d;
    req_dir[p]  = dr;
    req_amt[p]  = a;
    req_reps[p] = r;
  endtask

  // n counts edges from the accepting edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int n);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_data  = '0;
    req_dir   = '0;
    req_amt   = '0;
    req_reps  = '0;
    step();
    step();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data",  rsp_data,  8'h00);
    chk("rst_rsp_id",    rsp_id,    0);
    chk("rst_busy",      busy,      0);
    chk("rst_req_ready", req_ready, 2'b00);
    rst_n = 1'b1;
    step();

    // 1: single rotate left 3 of B4
    set_req(0, 8'hB4, 1'b1, 3'd3, 2'd0);
    req_valid = 2'b01;
    #1;
    chk("t1_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("t1_busy_run",  busy,      1);
    chk("t1_ready_run", req_ready, 2'b00);
    chk("t1_valid_run", rsp_valid, 0);
    wait_rsp(lat);
    chk("t1_latency", lat, 2);
    chk("t1_data",    rsp_data, 8'hA5);
    chk("t1_id",      rsp_id,   0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t1_valid_after", rsp_valid, 0);
    chk("t1_busy_after",  busy,      0);

    // 2: four single-bit right rotates of 81
    set_req(1, 8'h81, 1'b0, 3'd1, 2'd3);
    req_valid = 2'b10;
    #1;
    chk("t2_req_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    wait_rsp(lat);
    chk("t2_latency", lat, 5);
    chk("t2_data",    rsp_data, 8'h18);
    chk("t2_id",      rsp_id,   1);
    rsp_ready = 1'b1;
    step();
    chk("t2_valid_after", rsp_valid, 0);

    // 3: contention from reset, grant order 0,1,0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 8'h11, 1'b1, 3'd1, 2'd0);
    set_req(1, 8'h11, 1'b0, 3'd1, 2'd0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_not_both", (req_ready == 2'b11), 0);
      chk("t3_grant", req_ready, (k == 1) ? 2'b10 : 2'b01);
      step();
      wait_rsp(lat);
      chk("t3_latency", lat, 2);
      chk("t3_id",   rsp_id,   (k == 1) ? 1 : 0);
      chk("t3_data", rsp_data, (k == 1) ? 8'h88 : 8'h22);
      step();
      chk("t3_idle", busy, 0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;

    // 4: backpressure in DONE; 0F rotated right 2 twice gives F0
    set_req(0, 8'h0F, 1'b0, 3'd2, 2'd1);
    req_valid = 2'b01;
    step();
    req_valid = 2'b10;
    set_req(1, 8'hFF, 1'b1, 3'd5, 2'd3);
    wait_rsp(lat);
    chk("t4_latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      chk("t4_valid", rsp_valid, 1);
      chk("t4_data",  rsp_data,  8'hF0);
      chk("t4_id",    rsp_id,    0);
      chk("t4_ready", req_ready, 2'b00);
      chk("t4_busy",  busy,      1);
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t4_valid_after", rsp_valid, 0);
    chk("t4_busy_after",  busy,      0);

    // 5: reset during second pass of a reps=3 command aborts it
    set_req(1, 8'h81, 1'b0, 3'd1, 2'd3);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_valid", rsp_valid, 0);
    chk("t5_busy",  busy,      0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t5_no_rsp", rsp_valid, 0);
    end
    set_req(0, 8'h5A, 1'b1, 3'd4, 2'd0);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    wait_rsp(lat);
    chk("t5_latency", lat, 2);
    chk("t5_data",    rsp_data, 8'hA5);
    chk("t5_id",      rsp_id,   0);
    step();

    // 6: zero amount passes data through
    set_req(1, 8'h5A, 1'b1, 3'd0, 2'd3);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    wait_rsp(lat);
    chk("t6_latency", lat, 5);
    chk("t6_data",    rsp_data, 8'h5A);
    chk("t6_id",      rsp_id,   1);
    step();
    chk("t6_valid_after", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
